// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe encodings: outcomes, square/user codes, judge states and the 8 line masks.
// Used by the move judge, the turn FSM and the display logic.
package tictactoe_pkg;

    typedef enum logic [2:0] {
        OUT_IN_PROGRESS = 3'd0,
        OUT_P1_WIN      = 3'd1,
        OUT_P1_LOSE     = 3'd2,
        OUT_TIE         = 3'd3
    } outcome_e;

    typedef enum logic [3:0] {
        SQ_NONE = 4'd0,
        SQ_A1   = 4'd1,
        SQ_A2   = 4'd2,
        SQ_A3   = 4'd3,
        SQ_B1   = 4'd4,
        SQ_B2   = 4'd5,
        SQ_B3   = 4'd6,
        SQ_C1   = 4'd7,
        SQ_C2   = 4'd8,
        SQ_C3   = 4'd9
    } square_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_OVER  = 2'd2
    } judge_state_e;

    localparam logic [1:0] USER_P1     = 2'b01;
    localparam logic [1:0] USER_P2     = 2'b10;
    localparam logic [3:0] NUM_SQUARES = 4'd9;

    // Rows A-C, columns 1-3, diagonal A1-C3, diagonal A3-C1; bit k-1 = square k.
    localparam logic [8:0] LINE_MASK [8] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    function automatic logic [8:0] square_mask(input logic [3:0] sq);
        logic [8:0] mask;
        mask = '0;
        if (sq >= 4'd1 && sq <= NUM_SQUARES)
            mask = 9'd1 << (sq - 4'd1);
        return mask;
    endfunction

    function automatic logic user_legal(input logic [1:0] usr);
        return (usr == USER_P1) || (usr == USER_P2);
    endfunction

endpackage

// File: rtl/line_detect.sv
// Combinational line finder: flags every line fully covered by one player's board.
module line_detect
    import tictactoe_pkg::*;
(
    input  logic [8:0] board_i,
    output logic [7:0] lines_o
);

    for (genvar i = 0; i < 8; i++) begin : g_line
        assign lines_o[i] = ((board_i & LINE_MASK[i]) == LINE_MASK[i]);
    end

endmodule

// File: rtl/move_judge.sv
// Move referee: validates checks, applies committed moves and registers outcome/win line.
// State table: IDLE = no validated move pending | ARMED = check passed, move/user latched | OVER = outcome non-zero
module move_judge
    import tictactoe_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic [3:0] move_i,
    input  logic [1:0] user_i,
    input  logic       check_i,
    input  logic       commit_i,
    output logic       valid_o,
    output logic [2:0] outcome_o,
    output logic [8:0] board_p1_o,
    output logic [8:0] board_p2_o,
    output logic [7:0] win_line_o,
    output logic [3:0] move_count_o,
    output logic       err_o
);

    judge_state_e state_q, state_d;
    outcome_e     outcome_q, outcome_d;
    logic [8:0]   board_p1_q, board_p1_d;
    logic [8:0]   board_p2_q, board_p2_d;
    logic [7:0]   win_line_q, win_line_d;
    logic [3:0]   move_count_q, move_count_d;
    logic [3:0]   move_q, move_d;
    logic [1:0]   user_q, user_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;

    logic [8:0]   mover_next;
    logic [7:0]   lines;
    logic [3:0]   count_inc;
    logic         check_pass;

    // Win/tie is judged on the board as it will be after this commit.
    assign mover_next = ((user_q == USER_P1) ? board_p1_q : board_p2_q) | square_mask(move_q);
    assign count_inc  = move_count_q + 4'd1;
    assign check_pass = (square_mask(move_i) != 9'd0) && user_legal(user_i)
                        && ((square_mask(move_i) & (board_p1_q | board_p2_q)) == 9'd0);

    line_detect u_line_detect (
        .board_i (mover_next),
        .lines_o (lines)
    );

    always_comb begin
        state_d      = state_q;
        outcome_d    = outcome_q;
        board_p1_d   = board_p1_q;
        board_p2_d   = board_p2_q;
        win_line_d   = win_line_q;
        move_count_d = move_count_q;
        move_d       = move_q;
        user_d       = user_q;
        valid_d      = valid_q;
        err_d        = 1'b0;

        if (commit_i) begin
            if (state_q == ST_ARMED) begin
                if (user_q == USER_P1) board_p1_d = mover_next;
                else                   board_p2_d = mover_next;
                move_count_d = count_inc;
                valid_d      = 1'b0;
                win_line_d   = lines;
                if (lines != 8'd0) begin
                    outcome_d = (user_q == USER_P1) ? OUT_P1_WIN : OUT_P1_LOSE;
                    state_d   = ST_OVER;
                end else if (count_inc == NUM_SQUARES) begin
                    outcome_d = OUT_TIE;
                    state_d   = ST_OVER;
                end else begin
                    state_d   = ST_IDLE;
                end
            end else begin
                err_d = 1'b1;
            end
        end else if (check_i) begin
            if (state_q == ST_OVER) begin
                valid_d = 1'b0;
            end else if (check_pass) begin
                valid_d = 1'b1;
                move_d  = move_i;
                user_d  = user_i;
                state_d = ST_ARMED;
            end else begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q      <= ST_IDLE;
            outcome_q    <= OUT_IN_PROGRESS;
            board_p1_q   <= '0;
            board_p2_q   <= '0;
            win_line_q   <= '0;
            move_count_q <= '0;
            move_q       <= '0;
            user_q       <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            outcome_q    <= outcome_d;
            board_p1_q   <= board_p1_d;
            board_p2_q   <= board_p2_d;
            win_line_q   <= win_line_d;
            move_count_q <= move_count_d;
            move_q       <= move_d;
            user_q       <= user_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    assign valid_o      = valid_q;
    assign outcome_o    = outcome_q;
    assign board_p1_o   = board_p1_q;
    assign board_p2_o   = board_p2_q;
    assign win_line_o   = win_line_q;
    assign move_count_o = move_count_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_move_judge.sv
// Directed bench for move_judge: expected output snapshots are queued at drive time
// and compared against the registered outputs one cycle later.
module tb_move_judge;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       clear_i = 1'b0;
    logic [3:0] move_i = '0;
    logic [1:0] user_i = '0;
    logic       check_i = 1'b0;
    logic       commit_i = 1'b0;
    logic       valid_o;
    logic [2:0] outcome_o;
    logic [8:0] board_p1_o;
    logic [8:0] board_p2_o;
    logic [7:0] win_line_o;
    logic [3:0] move_count_o;
    logic       err_o;

    move_judge dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .move_i       (move_i),
        .user_i       (user_i),
        .check_i      (check_i),
        .commit_i     (commit_i),
        .valid_o      (valid_o),
        .outcome_o    (outcome_o),
        .board_p1_o   (board_p1_o),
        .board_p2_o   (board_p2_o),
        .win_line_o   (win_line_o),
        .move_count_o (move_count_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Snapshot layout: {valid, outcome, win_line, board_p1, board_p2, move_count, err}
    typedef struct {
        string       tag;
        logic [34:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic       m_valid;
    logic [2:0] m_out;
    logic [7:0] m_win;
    logic [8:0] m_p1, m_p2;
    logic [3:0] m_cnt;
    logic       m_err;
    logic [3:0] m_mv;
    logic [1:0] m_us;

    task automatic push(input string tag);
        exp_t e;
        e.tag = tag;
        e.v   = {m_valid, m_out, m_win, m_p1, m_p2, m_cnt, m_err};
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t        e;
        logic [34:0] obs;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0; clear_i = 1'b0; check_i = 1'b0; commit_i = 1'b0;
        obs = {valid_o, outcome_o, win_line_o, board_p1_o, board_p2_o, move_count_o, err_o};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h required=entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic model_zero();
        m_valid = 0; m_out = 0; m_win = 0; m_p1 = 0; m_p2 = 0; m_cnt = 0; m_err = 0;
        m_mv = 0; m_us = 0;
    endtask

    task automatic do_reset(input logic use_rst, input logic with_commit, input string tag);
        @(negedge clk_i);
        rst_i = use_rst; clear_i = ~use_rst; commit_i = with_commit;
        move_i = 4'd1; user_i = 2'b01;
        model_zero();
        push(tag);
        step();
    endtask

    task automatic do_check(input logic [3:0] mv, input logic [1:0] us, input logic ev,
                            input string tag);
        @(negedge clk_i);
        move_i = mv; user_i = us; check_i = 1'b1;
        if (ev) begin m_mv = mv; m_us = us; end
        m_valid = ev; m_err = 0;
        push(tag);
        step();
    endtask

    // Live move/user are driven with junk to show only the latched move is placed.
    task automatic do_commit(input logic ok, input logic [2:0] eo, input logic [7:0] ew,
                             input string tag);
        @(negedge clk_i);
        move_i = 4'hF; user_i = 2'b11; commit_i = 1'b1;
        if (ok) begin
            if (m_us == 2'b01) m_p1[int'(m_mv) - 1] = 1'b1;
            else               m_p2[int'(m_mv) - 1] = 1'b1;
            m_cnt = m_cnt + 4'd1; m_valid = 0; m_out = eo; m_win = ew; m_err = 0;
        end else begin
            m_err = 1;
        end
        push(tag);
        step();
    endtask

    task automatic do_idle(input string tag);
        @(negedge clk_i);
        m_err = 0;
        push(tag);
        step();
    endtask

    task automatic play(input logic [3:0] mv, input logic [1:0] us, input logic [2:0] eo,
                        input logic [7:0] ew, input string tag);
        do_check(mv, us, 1'b1, {tag, "_chk"});
        do_commit(1'b1, eo, ew, {tag, "_cmt"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_zero();
        do_reset(1'b1, 1'b0, "reset");
        do_idle("reset_hold");

        play(4'd5, 2'b01, 3'd0, 8'h00, "p1_b2");
        do_check(4'd5, 2'b10, 1'b0, "occupied");
        do_check(4'd0, 2'b10, 1'b0, "move0");
        do_check(4'd12, 2'b10, 1'b0, "move12");
        do_check(4'd4, 2'b11, 1'b0, "bad_user");
        do_commit(1'b0, 3'd0, 8'h00, "commit_idle_err");
        do_idle("err_one_cycle");

        do_check(4'd4, 2'b10, 1'b1, "arm_p2_b1");
        do_idle("valid_held");
        do_check(4'd6, 2'b10, 1'b1, "rearm_p2_b3");
        do_commit(1'b1, 3'd0, 8'h00, "commit_rearm");

        do_reset(1'b0, 1'b0, "clear_game");
        play(4'd1, 2'b01, 3'd0, 8'h00, "w1");
        play(4'd4, 2'b10, 3'd0, 8'h00, "w2");
        play(4'd2, 2'b01, 3'd0, 8'h00, "w3");
        play(4'd5, 2'b10, 3'd0, 8'h00, "w4");
        play(4'd3, 2'b01, 3'd1, 8'h01, "w5_row_a");
        do_check(4'd9, 2'b10, 1'b0, "check_over");
        do_commit(1'b0, 3'd0, 8'h00, "commit_over_err");

        do_reset(1'b0, 1'b0, "clear_over");
        play(4'd1, 2'b01, 3'd0, 8'h00, "t1");
        play(4'd2, 2'b10, 3'd0, 8'h00, "t2");
        play(4'd3, 2'b01, 3'd0, 8'h00, "t3");
        play(4'd5, 2'b10, 3'd0, 8'h00, "t4");
        play(4'd4, 2'b01, 3'd0, 8'h00, "t5");
        play(4'd6, 2'b10, 3'd0, 8'h00, "t6");
        play(4'd8, 2'b01, 3'd0, 8'h00, "t7");
        play(4'd7, 2'b10, 3'd0, 8'h00, "t8");
        play(4'd9, 2'b01, 3'd3, 8'h00, "t9_tie");

        do_reset(1'b1, 1'b0, "reset_over");
        play(4'd1, 2'b01, 3'd0, 8'h00, "d1");
        play(4'd3, 2'b10, 3'd0, 8'h00, "d2");
        play(4'd2, 2'b01, 3'd0, 8'h00, "d3");
        play(4'd4, 2'b10, 3'd0, 8'h00, "d4");
        play(4'd5, 2'b01, 3'd0, 8'h00, "d5");
        play(4'd7, 2'b10, 3'd0, 8'h00, "d6");
        play(4'd6, 2'b01, 3'd0, 8'h00, "d7");
        play(4'd8, 2'b10, 3'd0, 8'h00, "d8");
        play(4'd9, 2'b01, 3'd1, 8'h40, "d9_diag_win");

        do_reset(1'b0, 1'b0, "clear_diag");
        do_check(4'd1, 2'b01, 1'b1, "arm_before_clear");
        do_reset(1'b0, 1'b1, "clear_with_commit");
        do_commit(1'b0, 3'd0, 8'h00, "commit_after_clear_err");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_judge.md
# move_judge

Referee stage directly upstream of the turn-control FSM. Holds the authoritative 3x3 board occupancy for both players and answers the FSM's `check` request with a registered `valid`. Applies the move on `commit` and presents the registered game `outcome` in time for the FSM's next-cycle check state. Also exports the winning-line mask and move count for display logic.

## Interface
- No parameters; board size fixed at 3x3.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clear` in 1: synchronous new-game request; same effect as `rst`.
- `move` in 4: square code, 1=A1, 2=A2, 3=A3, 4=B1 … 9=C3; 0 and 10-15 illegal.
- `user` in 2: 2'b01=P1, 2'b10=P2; other values illegal.
- `check` in 1: one-cycle request to validate `move` for `user`.
- `commit` in 1: one-cycle request to place the previously validated move.
- `valid` out 1: registered result of the last `check`, held until the next `check`/`commit`/`clear`.
- `outcome` out 3: 0=in_progress, 1=p1_win, 2=p1_lose (P2 win), 3=tie.
- `board_p1`, `board_p2` out 9: occupancy; bit k-1 = square k.
- `win_line` out 8: one-hot winning line; bits 0-2 rows A-C, 3-5 columns 1-3, 6 = diagonal A1-C3, 7 = diagonal A3-C1.
- `move_count` out 4: squares filled, 0-9.
- `err` out 1: one-cycle pulse on an ignored `commit`.

## Operation
- Reset/clear values: all boards 0, `valid`=0, `outcome`=0, `win_line`=0, `move_count`=0, `err`=0, armed flag 0, latched move/user 0.
- Priority when events coincide: `rst`/`clear` > `commit` > `check`.
- Internal FSM:
  - IDLE: no validated move pending.
  - ARMED: a `check` passed; `move` and `user` are latched.
  - OVER: `outcome` is non-zero.
- `check` in IDLE or ARMED:
  - `valid` <= 1 only if all hold: `move` in 1..9, `user` legal, square free in both boards, and state is not OVER.
  - On pass: latch `move`/`user` and go to ARMED.
  - On fail: go to IDLE.
  - A re-check in ARMED replaces the latch.
- `check` in OVER: `valid` <= 0; state stays OVER.
- `commit` in ARMED:
  - Set the latched square in the latched player's board.
  - `move_count` += 1.
  - `valid` <= 0.
  - Evaluate win/tie on the next-board value (combinational) and register `outcome`/`win_line` on the same edge.
  - Go to OVER if the outcome is non-zero, else IDLE.
- `commit` in IDLE or OVER: no state change; `err` pulses for 1 cycle.
- Commit uses the latched move/user only; the live `move`/`user` inputs at commit time are ignored.
- Win detection: a line is won when all 3 of its squares are set in the mover's board. `win_line` may carry 2 bits (double line on one move).
- Outcome decision:
  - Win beats tie: the 9th move completing a line gives a win, not a tie.
  - Tie when `move_count` reaches 9 with no line.
  - Mover P1 gives 1; mover P2 gives 2.
- OVER persists until `rst`/`clear`.

## Timing
- `check` at cycle n -> `valid` visible at n+1. This matches the FSM sampling `valid` in its update state.
- `commit` at cycle n -> boards, `move_count`, `outcome`, `win_line` updated and visible at n+1. This matches the FSM sampling `outcome` in its check state.
- `err` is high exactly in cycle n+1 after an ignored commit.
- `rst`/`clear` at cycle n -> all outputs at reset values from n+1, including mid-ARMED or OVER.
- No combinational input-to-output paths; all outputs are registered.

## Structure
- Shared package `tictactoe_pkg` holds:
  - Outcome encodings (in_progress/p1_win/p1_lose/tie).
  - Square codes A1..C3.
  - User codes P1/P2.
  - The 8 line masks as 9-bit constants, shared with the turn FSM and display.
- Sub-module `line_detect`: combinational; 9-bit board in, 8-bit line mask out. Instantiated on the mover's next-board value.

## Test plan
- Reset, then P1 check move=5 -> `valid`=1 next cycle; commit -> `board_p1`=9'h010, `move_count`=1, `outcome`=0.
- P2 check move=5 after the previous case -> `valid`=0. Check move=0 -> `valid`=0. Check move=12 -> `valid`=0. Commit with no armed move -> `err` pulse, boards unchanged.
- P1 fills 1, 2, 3 (P2 plays 4, 5 between) -> after the third P1 commit `outcome`=1, `win_line`=8'h01. Any later check gives `valid`=0.
- Full board, no line (P1: 1,3,4,8,9; P2: 2,5,6,7) -> after 9th commit `outcome`=3, `move_count`=9, `win_line`=0.
- Ninth move completing P1 diagonal 1-5-9 -> `outcome`=1, not 3. Same-cycle `clear` and `commit` -> all zero, commit discarded.
